// File: rtl/div64_iter_pkg.sv
// Shared constants, state encoding and helpers for the iterative 64-bit divider.
package div64_iter_pkg;

   localparam int unsigned XLEN = 64;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StFix  = 2'd2,
      StDone = 2'd3
   } div_state_e;

   // Quotient returned for a zero divisor.
   localparam logic [XLEN-1:0] DivZeroQuo = {XLEN{1'b1}};

   // Two's-complement negation.
   function automatic logic [XLEN-1:0] neg64(input logic [XLEN-1:0] x);
      return ~x + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   // Magnitude of a signed operand; raw value when unsigned or non-negative.
   function automatic logic [XLEN-1:0] mag64(input logic [XLEN-1:0] x, input logic sgn);
      return (sgn && x[XLEN-1]) ? neg64(x) : x;
   endfunction

endpackage

// File: rtl/div64_iter_div_step64.sv
// One restoring-division iteration: shift {R, Q} left, trial-subtract D over 65 bits.
module div_step64
   import div64_iter_pkg::*;
(
   input  logic [XLEN:0]   r_i,
   input  logic [XLEN-1:0] q_i,
   input  logic [XLEN-1:0] d_i,
   output logic [XLEN:0]   r_o,
   output logic [XLEN-1:0] q_o
);

   logic [XLEN:0] r_sh;
   logic [XLEN:0] trial;

   // Shift, trial subtract and restore when the trial goes negative.
   always_comb begin
      r_sh  = {r_i[XLEN-1:0], q_i[XLEN-1]};
      trial = r_sh - {1'b0, d_i};
      // Partial remainder stays below D, so bit 64 of the trial is a valid sign.
      if (!trial[XLEN]) begin
         r_o = trial;
         q_o = {q_i[XLEN-2:0], 1'b1};
      end else begin
         r_o = r_sh;
         q_o = {q_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div64_iter.sv
// Multi-cycle RV64M divider: DIV/DIVU/REM/REMU via restoring division, one bit per cycle.
module div64_iter
   import div64_iter_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            sgn,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quo,
   output logic [XLEN-1:0] rem
);

   div_state_e      state_q, state_d;
   logic [XLEN:0]   r_q, r_d;
   logic [XLEN-1:0] q_q, q_d;
   logic [XLEN-1:0] d_q, d_d;
   logic [5:0]      cnt_q, cnt_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;

   logic [XLEN:0]   step_r;
   logic [XLEN-1:0] step_q;

   div_step64 u_step (
      .r_i (r_q),
      .q_i (q_q),
      .d_i (d_q),
      .r_o (step_r),
      .q_o (step_q)
   );

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      q_d       = q_q;
      d_d       = d_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      quo_d     = quo_q;
      rem_d     = rem_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (state_q == StDone) begin
               state_d = StIdle;
            end
            if (start) begin
               if (op2 == '0) begin
                  quo_d   = DivZeroQuo;
                  rem_d   = op1;
                  state_d = StDone;
               end else begin
                  q_d       = mag64(op1, sgn);
                  d_d       = mag64(op2, sgn);
                  neg_quo_d = sgn & (op1[XLEN-1] ^ op2[XLEN-1]);
                  neg_rem_d = sgn & op1[XLEN-1];
                  r_d       = '0;
                  cnt_d     = '0;
                  state_d   = StCalc;
               end
            end
         end
         StCalc: begin
            r_d   = step_r;
            q_d   = step_q;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd63) begin
               state_d = StFix;
            end
         end
         StFix: begin
            quo_d   = neg_quo_q ? neg64(q_q) : q_q;
            rem_d   = neg_rem_q ? neg64(r_q[XLEN-1:0]) : r_q[XLEN-1:0];
            state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset abandons any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         r_q       <= '0;
         q_q       <= '0;
         d_q       <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         quo_q     <= '0;
         rem_q     <= '0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         q_q       <= q_d;
         d_q       <= d_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
      end
   end

   // Outputs decode directly from registers.
   always_comb begin
      busy = (state_q == StCalc) || (state_q == StFix);
      done = (state_q == StDone);
      quo  = quo_q;
      rem  = rem_q;
   end

endmodule

// File: tb/tb_div64_iter.sv
// Scoreboard bench for div64_iter: stimulus pushes expected results, monitor pops on done.
module tb_div64_iter;

   logic        clk;
   logic        rst;
   logic        start;
   logic        sgn;
   logic [63:0] op1;
   logic [63:0] op2;
   logic        busy;
   logic        done;
   logic [63:0] quo;
   logic [63:0] rem;

   int n_cmp = 0;
   int n_bad = 0;

   logic [127:0] exp_q[$];
   logic [127:0] mon_e;

   localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

   div64_iter dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sgn   (sgn),
      .op1   (op1),
      .op2   (op2),
      .busy  (busy),
      .done  (done),
      .quo   (quo),
      .rem   (rem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 required no pending result");
         end else begin
            mon_e = exp_q.pop_front();
            check64("quo", quo, mon_e[127:64]);
            check64("rem", rem, mon_e[63:0]);
         end
      end
   end

   // Wait (bounded) for done after the accepting edge; returns edges elapsed and busy cycles.
   task automatic wait_done(output int lat, output int bc);
      lat = 0;
      bc  = 0;
      while (1) begin
         if (busy === 1'b1) bc++;
         if (done === 1'b1) break;
         if (lat >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no done after %0d cycles required done", lat);
            break;
         end
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string name, input logic s, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] eq, input logic [63:0] er,
                         input int exp_lat, input int exp_busy);
      int lat;
      int bc;
      @(negedge clk);
      sgn   = s;
      op1   = a;
      op2   = b;
      start = 1'b1;
      exp_q.push_back({eq, er});
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, bc);
      check64({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check64({name, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int bc;
      int seen;
      rst   = 1'b1;
      start = 1'b0;
      sgn   = 1'b0;
      op1   = '0;
      op2   = '0;
      repeat (3) @(negedge clk);
      check64("reset_busy", 64'(busy), 64'd0);
      check64("reset_done", 64'(done), 64'd0);
      check64("reset_quo", quo, 64'd0);
      check64("reset_rem", rem, 64'd0);
      rst = 1'b0;

      run_op("u100_7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 65);
      run_op("sm100_7", 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
             64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 65);
      run_op("sm100_m7", 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
             64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 65, 65);
      run_op("div0_u", 1'b0, 64'h1234, 64'd0, Ones, 64'h1234, 0, 0);
      run_op("div0_s", 1'b1, 64'h1234, 64'd0, Ones, 64'h1234, 0, 0);
      run_op("ovf", 1'b1, 64'h8000_0000_0000_0000, Ones, 64'h8000_0000_0000_0000, 64'd0, 65, 65);
      run_op("u_ones_1", 1'b0, Ones, 64'd1, Ones, 64'd0, 65, 65);

      // Start pulsed mid-operation with other operands must be ignored.
      @(negedge clk);
      sgn   = 1'b0;
      op1   = 64'hDEAD_BEEF;
      op2   = 64'h10;
      start = 1'b1;
      exp_q.push_back({64'h0DEA_DBEE, 64'hF});
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      op1   = 64'd1000;
      op2   = 64'd10;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, bc);
      check64("ignored_start_latency", 64'(lat + 11), 64'd65);

      // Back-to-back: start held through the done cycle.
      @(negedge clk);
      sgn   = 1'b0;
      op1   = 64'd1000;
      op2   = 64'd3;
      start = 1'b1;
      exp_q.push_back({64'd333, 64'd1});
      exp_q.push_back({64'hFFFF_FFFF_FFFF_FEB3, Ones});
      @(posedge clk);
      #1;
      sgn = 1'b1;
      op1 = 64'hFFFF_FFFF_FFFF_FC18;
      wait_done(lat, bc);
      check64("b2b_first_latency", 64'(lat), 64'd65);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, bc);
      check64("b2b_gap", 64'(lat + 1), 64'd66);
      check64("b2b_second_busy", 64'(bc), 64'd65);

      // Reset in the middle of CALC abandons the operation.
      @(negedge clk);
      sgn   = 1'b0;
      op1   = Ones;
      op2   = 64'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check64("rst_mid_busy", 64'(busy), 64'd0);
      check64("rst_mid_done", 64'(done), 64'd0);
      check64("rst_mid_quo", quo, 64'd0);
      check64("rst_mid_rem", rem, 64'd0);
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen++;
      end
      check64("rst_no_done", 64'(seen), 64'd0);

      run_op("after_rst", 1'b0, 64'd12345, 64'd100, 64'd123, 64'd45, 65, 65);

      repeat (3) @(negedge clk);
      check64("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
